check_queue: RTL and testbench
==============================

Name: check_queue

Overview:
- Parametrised successor to the single-register check stage between decode stage 2 and scheduler stage 1.
- Replaces the one-deep register with a DEPTH-entry in-order instruction FIFO using valid/ready handshakes on both sides.
- Presents the head entry to the scheduler with an accept flag, CSR field and occupancy count.
- Absorbs scheduler back-pressure so decode keeps running until the queue fills.

Parameters:
XLEN, 32, width of PC and IMM
OPCODE_W, 17, width of packed opcode field
REG_W, 5, register index width (RD/RS1/RS2)
CSR_W, 12, CSR address width; taken from IMM[CSR_W-1:0]
DEPTH, 4, number of entries; legal range 2..16, any integer (not restricted to powers of two)
INVALID_IMM, {XLEN{1'b1}}, IMM marker for a non-accepted (illegal) instruction

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
FLUSH  in  1  synchronous queue clear (branch/trap redirect)
STALL  in  1  pipeline stall; blocks dequeue only
MEM_WAIT  in  1  memory wait; blocks dequeue only
IN_VALID  in  1  decode-2 entry valid
IN_READY  out  1  queue can accept an entry this cycle
PC  in  XLEN  entry PC
OPCODE  in  OPCODE_W  entry opcode
RD  in  REG_W  destination register
RS1  in  REG_W  source register 1
RS2  in  REG_W  source register 2
IMM  in  XLEN  immediate / CSR carrier
OUT_VALID  out  1  head entry present
OUT_READY  in  1  scheduler-1 takes head
CHECK_ACCEPT  out  1  head valid and head IMM != INVALID_IMM
CHECK_PC  out  XLEN  head PC
CHECK_OPCODE  out  OPCODE_W  head opcode
CHECK_RD  out  REG_W  head RD
CHECK_RS1  out  REG_W  head RS1
CHECK_RS2  out  REG_W  head RS2
CHECK_CSR  out  CSR_W  head IMM[CSR_W-1:0]
CHECK_IMM  out  XLEN  head IMM
COUNT  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (RST=1, asynchronous): wr_ptr, rd_ptr and count cleared to 0. IN_READY=1 once RST deasserts; OUT_VALID=0; CHECK_ACCEPT=0; all CHECK_* data outputs 0; COUNT=0. Entry storage needs no reset.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- IN_READY = (count < DEPTH) && !FLUSH. This is combinational.
- Full-queue rule: no bypass. When full, a same-cycle dequeue does not raise IN_READY within that cycle.
- Enqueue fires on IN_VALID && IN_READY. The entry is written at wr_ptr, and wr_ptr advances modulo DEPTH (wraps from DEPTH-1 to 0).
- Dequeue fires on OUT_VALID && OUT_READY && !STALL && !MEM_WAIT. rd_ptr advances modulo DEPTH.
- STALL/MEM_WAIT freeze the head and hold all CHECK_* outputs stable. Enqueue is still permitted while they are asserted.
- Latency: an entry enqueued into an empty queue appears on OUT_VALID/CHECK_* in the next cycle (1 cycle, same as the previous check stage).
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- OUT_VALID = (count != 0).
- CHECK_* outputs are driven from the head entry when OUT_VALID=1, and are forced to 0 when empty. Stale storage is never visible.
- CHECK_ACCEPT = OUT_VALID && (head IMM != INVALID_IMM).
- An invalid-marked entry still dequeues normally. The scheduler decides how to trap on it.
- FLUSH (synchronous, highest priority after RST): at the next edge, count, wr_ptr and rd_ptr are set to 0. An enqueue or dequeue in the same cycle is ignored.
- After FLUSH, OUT_VALID=0 in the following cycle.
- COUNT is registered and equals the number of held entries; it never exceeds DEPTH.

Test Plan:
- Reset/basic: assert RST asynchronously between edges -> OUT_VALID=0, COUNT=0, CHECK_PC=0 without any clock edge. Then enqueue PC=0x100, IMM=0x0000_0305 -> next cycle OUT_VALID=1, CHECK_PC=0x100, CHECK_CSR=0x305, CHECK_ACCEPT=1.
- Fill/wrap (DEPTH=4): hold OUT_READY=0 and enqueue PC 0x0,0x4,0x8,0xC -> COUNT=4, IN_READY=0. A fifth IN_VALID is dropped. Then set OUT_READY=1 and enqueue 0x10,0x14 as slots free -> output order 0x0,0x4,0x8,0xC,0x10,0x14 across the pointer wrap.
- Stall: with 2 entries queued, assert STALL for 3 cycles with OUT_READY=1 and IN_VALID=1 -> head unchanged, COUNT goes 2->3->4->4, IN_READY drops at 4.
- MEM_WAIT: same sequence as the stall scenario -> identical response.
- Invalid marker: enqueue IMM=0xFFFF_FFFF -> OUT_VALID=1, CHECK_ACCEPT=0, CHECK_IMM=0xFFFF_FFFF. Entry dequeues on OUT_READY.
- Flush collision: COUNT=3, with IN_VALID=1, OUT_READY=1 and FLUSH=1 in the same cycle -> next cycle COUNT=0, OUT_VALID=0. The colliding input PC never appears on CHECK_PC.
- Non-power-of-two: DEPTH=3 build, 10 back-to-back entries with randomised OUT_READY -> in-order delivery, COUNT<=3 throughout.

Source files
------------

// File: rtl/check_queue_if.sv
// check_queue_if: groups the decode-2 facing and scheduler-1 facing signals
// of the check queue.
//   Enqueue side : IN_VALID/IN_READY handshake plus PC, OPCODE, RD, RS1, RS2, IMM.
//   Dequeue side : OUT_VALID/OUT_READY handshake plus the CHECK_* head fields
//                  and the COUNT occupancy.
// slave  modport : the queue itself.
// master modport : the surrounding pipeline (decode feeds, scheduler drains).
interface check_queue_if #(
  parameter int XLEN     = 32,
  parameter int OPCODE_W = 17,
  parameter int REG_W    = 5,
  parameter int CSR_W    = 12,
  parameter int DEPTH    = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                IN_VALID;
  logic                IN_READY;
  logic [XLEN-1:0]     PC;
  logic [OPCODE_W-1:0] OPCODE;
  logic [REG_W-1:0]    RD;
  logic [REG_W-1:0]    RS1;
  logic [REG_W-1:0]    RS2;
  logic [XLEN-1:0]     IMM;

  logic                OUT_VALID;
  logic                OUT_READY;
  logic                CHECK_ACCEPT;
  logic [XLEN-1:0]     CHECK_PC;
  logic [OPCODE_W-1:0] CHECK_OPCODE;
  logic [REG_W-1:0]    CHECK_RD;
  logic [REG_W-1:0]    CHECK_RS1;
  logic [REG_W-1:0]    CHECK_RS2;
  logic [CSR_W-1:0]    CHECK_CSR;
  logic [XLEN-1:0]     CHECK_IMM;
  logic [CNT_W-1:0]    COUNT;

  modport slave (
    input  IN_VALID, PC, OPCODE, RD, RS1, RS2, IMM, OUT_READY,
    output IN_READY, OUT_VALID, CHECK_ACCEPT, CHECK_PC, CHECK_OPCODE,
           CHECK_RD, CHECK_RS1, CHECK_RS2, CHECK_CSR, CHECK_IMM, COUNT
  );

  modport master (
    output IN_VALID, PC, OPCODE, RD, RS1, RS2, IMM, OUT_READY,
    input  IN_READY, OUT_VALID, CHECK_ACCEPT, CHECK_PC, CHECK_OPCODE,
           CHECK_RD, CHECK_RS1, CHECK_RS2, CHECK_CSR, CHECK_IMM, COUNT
  );
endinterface

// File: rtl/check_queue.sv
// check_queue: DEPTH-entry in-order instruction FIFO between decode stage 2
// and scheduler stage 1.
//   CLK      : rising-edge clock
//   RST      : asynchronous active-high reset (empties the queue)
//   FLUSH    : synchronous clear, wins over any same-cycle enqueue/dequeue
//   STALL    : blocks dequeue only
//   MEM_WAIT : blocks dequeue only
//   q        : check_queue_if.slave, enqueue and dequeue handshakes, head
//              fields (forced to zero when empty), accept flag, occupancy.
module check_queue #(
  parameter int              XLEN        = 32,
  parameter int              OPCODE_W    = 17,
  parameter int              REG_W       = 5,
  parameter int              CSR_W       = 12,
  parameter int              DEPTH       = 4,
  parameter logic [XLEN-1:0] INVALID_IMM = {XLEN{1'b1}}
) (
  input logic          CLK,
  input logic          RST,
  input logic          FLUSH,
  input logic          STALL,
  input logic          MEM_WAIT,
  check_queue_if.slave q
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 2 * XLEN + OPCODE_W + 3 * REG_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               in_ready;
  logic               out_valid;
  logic               enq;
  logic               deq;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head;

  logic [XLEN-1:0]     head_pc;
  logic [OPCODE_W-1:0] head_opcode;
  logic [REG_W-1:0]    head_rd, head_rs1, head_rs2;
  logic [XLEN-1:0]     head_imm;

  // Handshakes. IN_READY looks only at the registered count, so a full queue
  // stays not-ready for the whole cycle even if the head leaves in it.
  always_comb begin
    in_ready  = (count_q < FULL_CNT) && !FLUSH;
    out_valid = (count_q != '0);
    enq       = q.IN_VALID && in_ready;
    deq       = out_valid && q.OUT_READY && !STALL && !MEM_WAIT;
    entry_in  = {q.PC, q.OPCODE, q.RD, q.RS1, q.RS2, q.IMM};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Explicit wrap keeps non-power-of-two depths correct.
      if (enq) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked purely by count_q.
  always_ff @(posedge CLK) begin
    if (enq) mem_q[wr_ptr_q] <= entry_in;
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    {head_pc, head_opcode, head_rd, head_rs1, head_rs2, head_imm} = head;
  end

  // Head presentation; zeros when empty so stale storage never leaks out.
  always_comb begin
    q.IN_READY     = in_ready;
    q.OUT_VALID    = out_valid;
    q.COUNT        = count_q;
    q.CHECK_ACCEPT = 1'b0;
    q.CHECK_PC     = '0;
    q.CHECK_OPCODE = '0;
    q.CHECK_RD     = '0;
    q.CHECK_RS1    = '0;
    q.CHECK_RS2    = '0;
    q.CHECK_CSR    = '0;
    q.CHECK_IMM    = '0;
    if (out_valid) begin
      q.CHECK_ACCEPT = (head_imm != INVALID_IMM);
      q.CHECK_PC     = head_pc;
      q.CHECK_OPCODE = head_opcode;
      q.CHECK_RD     = head_rd;
      q.CHECK_RS1    = head_rs1;
      q.CHECK_RS2    = head_rs2;
      q.CHECK_CSR    = head_imm[CSR_W-1:0];
      q.CHECK_IMM    = head_imm;
    end
  end
endmodule

// File: tb/tb_check_queue.sv
// tb_check_queue: directed bench for check_queue. One DEPTH=4 instance covers
// reset, fill/wrap, stall, memory wait, invalid marker and flush; a DEPTH=3
// instance covers non-power-of-two wrap with random scheduler back-pressure.
module tb_check_queue;
  logic clk;
  logic rst;
  logic flush_a, stall_a, mem_wait_a;
  logic flush_b, stall_b, mem_wait_b;
  int   checks;
  int   errors;

  check_queue_if #(.DEPTH(4)) qa ();
  check_queue_if #(.DEPTH(3)) qb ();

  check_queue #(.DEPTH(4)) dut_a (
    .CLK(clk), .RST(rst), .FLUSH(flush_a), .STALL(stall_a),
    .MEM_WAIT(mem_wait_a), .q(qa.slave)
  );

  check_queue #(.DEPTH(3)) dut_b (
    .CLK(clk), .RST(rst), .FLUSH(flush_b), .STALL(stall_b),
    .MEM_WAIT(mem_wait_b), .q(qb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in_a(input logic v, input logic [31:0] pc, input logic [31:0] imm);
    qa.IN_VALID = v;
    qa.PC       = pc;
    qa.OPCODE   = pc[16:0];
    qa.RD       = 5'd3;
    qa.RS1      = 5'd4;
    qa.RS2      = 5'd5;
    qa.IMM      = imm;
  endtask

  task automatic set_in_b(input logic v, input logic [31:0] pc);
    qb.IN_VALID = v;
    qb.PC       = pc;
    qb.OPCODE   = pc[16:0];
    qb.RD       = 5'd1;
    qb.RS1      = 5'd2;
    qb.RS2      = 5'd3;
    qb.IMM      = 32'h0000_0042;
  endtask

  task automatic test_reset();
    checks++; if (qa.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", qa.OUT_VALID); end
    checks++; if (qa.COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", qa.COUNT); end
    checks++; if (qa.CHECK_PC !== 32'h0) begin errors++; $display("FAIL reset_check_pc got %h exp 0", qa.CHECK_PC); end
    checks++; if (qa.CHECK_ACCEPT !== 1'b0) begin errors++; $display("FAIL reset_accept got %b exp 0", qa.CHECK_ACCEPT); end
    rst = 1'b0;
    #1;
    checks++; if (qa.IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", qa.IN_READY); end
    tick();
    set_in_a(1'b1, 32'h100, 32'h0000_0305);
    tick();
    set_in_a(1'b0, 32'h0, 32'h0);
    checks++; if (qa.OUT_VALID !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", qa.OUT_VALID); end
    checks++; if (qa.CHECK_PC !== 32'h100) begin errors++; $display("FAIL basic_pc got %h exp 100", qa.CHECK_PC); end
    checks++; if (qa.CHECK_CSR !== 12'h305) begin errors++; $display("FAIL basic_csr got %h exp 305", qa.CHECK_CSR); end
    checks++; if (qa.CHECK_ACCEPT !== 1'b1) begin errors++; $display("FAIL basic_accept got %b exp 1", qa.CHECK_ACCEPT); end
    checks++; if (qa.COUNT !== 3'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", qa.COUNT); end
    checks++; if (qa.CHECK_OPCODE !== 17'h100) begin errors++; $display("FAIL basic_opcode got %h exp 100", qa.CHECK_OPCODE); end
    checks++; if ({qa.CHECK_RD, qa.CHECK_RS1, qa.CHECK_RS2} !== {5'd3, 5'd4, 5'd5}) begin
      errors++; $display("FAIL basic_regs got %0d/%0d/%0d exp 3/4/5", qa.CHECK_RD, qa.CHECK_RS1, qa.CHECK_RS2);
    end
    // Asynchronous reset between edges.
    #3;
    rst = 1'b1;
    #1;
    checks++; if (qa.OUT_VALID !== 1'b0) begin errors++; $display("FAIL async_rst_out_valid got %b exp 0", qa.OUT_VALID); end
    checks++; if (qa.COUNT !== 3'd0) begin errors++; $display("FAIL async_rst_count got %0d exp 0", qa.COUNT); end
    checks++; if (qa.CHECK_PC !== 32'h0) begin errors++; $display("FAIL async_rst_pc got %h exp 0", qa.CHECK_PC); end
    #1;
    rst = 1'b0;
    tick();
    checks++; if (qa.COUNT !== 3'd0) begin errors++; $display("FAIL post_rst_count got %0d exp 0", qa.COUNT); end
    $display("test_reset done");
  endtask

  task automatic test_fill_wrap();
    logic [31:0] exp_q[$];
    logic [31:0] pend[$];
    int mcnt;
    int seen;
    qa.OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in_a(1'b1, 32'(i * 4), 32'h10 + 32'(i));
      #1;
      checks++; if (qa.IN_READY !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got %b exp 1", i, qa.IN_READY); end
      tick();
    end
    set_in_a(1'b0, 32'h0, 32'h0);
    checks++; if (qa.COUNT !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", qa.COUNT); end
    checks++; if (qa.IN_READY !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", qa.IN_READY); end
    set_in_a(1'b1, 32'h99, 32'h0);
    tick();
    set_in_a(1'b0, 32'h0, 32'h0);
    checks++; if (qa.COUNT !== 3'd4) begin errors++; $display("FAIL drop_count got %0d exp 4", qa.COUNT); end
    checks++; if (qa.CHECK_PC !== 32'h0) begin errors++; $display("FAIL drop_head got %h exp 0", qa.CHECK_PC); end
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    pend  = {32'h10, 32'h14};
    mcnt  = 4;
    seen  = 0;
    qa.OUT_READY = 1'b1;
    for (int cyc = 0; cyc < 20 && seen < 6; cyc++) begin
      bit do_enq, do_deq;
      if (pend.size() > 0) set_in_a(1'b1, pend[0], 32'h0);
      else set_in_a(1'b0, 32'h0, 32'h0);
      #1;
      checks++; if (qa.IN_READY !== 1'(mcnt < 4)) begin errors++; $display("FAIL wrap_in_ready cyc%0d got %b exp %b", cyc, qa.IN_READY, mcnt < 4); end
      if (mcnt > 0) begin
        checks++; if (qa.CHECK_PC !== exp_q[0]) begin errors++; $display("FAIL wrap_order cyc%0d got %h exp %h", cyc, qa.CHECK_PC, exp_q[0]); end
      end
      do_deq = (mcnt > 0);
      do_enq = (pend.size() > 0) && (mcnt < 4);
      tick();
      if (do_deq) begin void'(exp_q.pop_front()); seen++; mcnt--; end
      if (do_enq) begin exp_q.push_back(pend.pop_front()); mcnt++; end
    end
    set_in_a(1'b0, 32'h0, 32'h0);
    qa.OUT_READY = 1'b0;
    checks++; if (seen != 6) begin errors++; $display("FAIL wrap_delivered got %0d exp 6", seen); end
    checks++; if (qa.COUNT !== 3'd0) begin errors++; $display("FAIL wrap_final_count got %0d exp 0", qa.COUNT); end
    $display("test_fill_wrap done");
  endtask

  task automatic test_hold(input bit use_mem_wait);
    int ec[3];
    logic [31:0] dp[4];
    ec = '{3, 4, 4};
    dp = '{32'h200, 32'h204, 32'h208, 32'h20C};
    qa.OUT_READY = 1'b0;
    set_in_a(1'b1, 32'h200, 32'h1); tick();
    set_in_a(1'b1, 32'h204, 32'h2); tick();
    checks++; if (qa.COUNT !== 3'd2) begin errors++; $display("FAIL hold%0d_pre_count got %0d exp 2", use_mem_wait, qa.COUNT); end
    if (use_mem_wait) mem_wait_a = 1'b1;
    else stall_a = 1'b1;
    qa.OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in_a(1'b1, 32'h208 + 32'(4 * k), 32'h3);
      tick();
      checks++; if (qa.CHECK_PC !== 32'h200) begin errors++; $display("FAIL hold%0d_head[%0d] got %h exp 200", use_mem_wait, k, qa.CHECK_PC); end
      checks++; if (qa.COUNT !== 3'(ec[k])) begin errors++; $display("FAIL hold%0d_count[%0d] got %0d exp %0d", use_mem_wait, k, qa.COUNT, ec[k]); end
    end
    set_in_a(1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (qa.IN_READY !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got %b exp 0", use_mem_wait, qa.IN_READY); end
    stall_a = 1'b0;
    mem_wait_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (qa.CHECK_PC !== dp[k]) begin errors++; $display("FAIL hold%0d_drain[%0d] got %h exp %h", use_mem_wait, k, qa.CHECK_PC, dp[k]); end
      tick();
    end
    qa.OUT_READY = 1'b0;
    checks++; if (qa.OUT_VALID !== 1'b0) begin errors++; $display("FAIL hold%0d_empty got %b exp 0", use_mem_wait, qa.OUT_VALID); end
    $display("test_hold mem_wait=%0d done", use_mem_wait);
  endtask

  task automatic test_invalid();
    qa.OUT_READY = 1'b0;
    set_in_a(1'b1, 32'h300, 32'hFFFF_FFFF);
    tick();
    set_in_a(1'b0, 32'h0, 32'h0);
    checks++; if (qa.OUT_VALID !== 1'b1) begin errors++; $display("FAIL inv_out_valid got %b exp 1", qa.OUT_VALID); end
    checks++; if (qa.CHECK_ACCEPT !== 1'b0) begin errors++; $display("FAIL inv_accept got %b exp 0", qa.CHECK_ACCEPT); end
    checks++; if (qa.CHECK_IMM !== 32'hFFFF_FFFF) begin errors++; $display("FAIL inv_imm got %h exp ffffffff", qa.CHECK_IMM); end
    checks++; if (qa.CHECK_CSR !== 12'hFFF) begin errors++; $display("FAIL inv_csr got %h exp fff", qa.CHECK_CSR); end
    qa.OUT_READY = 1'b1;
    tick();
    qa.OUT_READY = 1'b0;
    checks++; if (qa.COUNT !== 3'd0) begin errors++; $display("FAIL inv_deq_count got %0d exp 0", qa.COUNT); end
    checks++; if (qa.CHECK_IMM !== 32'h0) begin errors++; $display("FAIL inv_empty_imm got %h exp 0", qa.CHECK_IMM); end
    $display("test_invalid done");
  endtask

  task automatic test_flush();
    qa.OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in_a(1'b1, 32'h400 + 32'(4 * i), 32'h5);
      tick();
    end
    checks++; if (qa.COUNT !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", qa.COUNT); end
    set_in_a(1'b1, 32'h4AA, 32'h5);
    qa.OUT_READY = 1'b1;
    flush_a = 1'b1;
    #1;
    checks++; if (qa.IN_READY !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", qa.IN_READY); end
    tick();
    flush_a = 1'b0;
    set_in_a(1'b0, 32'h0, 32'h0);
    qa.OUT_READY = 1'b0;
    checks++; if (qa.COUNT !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", qa.COUNT); end
    checks++; if (qa.OUT_VALID !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", qa.OUT_VALID); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (qa.CHECK_PC === 32'h4AA) begin errors++; $display("FAIL flush_leak[%0d] got %h exp not 4aa", k, qa.CHECK_PC); end
    end
    set_in_a(1'b1, 32'h500, 32'h7);
    tick();
    set_in_a(1'b0, 32'h0, 32'h0);
    checks++; if (qa.CHECK_PC !== 32'h500) begin errors++; $display("FAIL flush_after_pc got %h exp 500", qa.CHECK_PC); end
    checks++; if (qa.COUNT !== 3'd1) begin errors++; $display("FAIL flush_after_count got %0d exp 1", qa.COUNT); end
    qa.OUT_READY = 1'b1;
    tick();
    qa.OUT_READY = 1'b0;
    $display("test_flush done");
  endtask

  task automatic test_non_pow2();
    logic [31:0] exp_q[$];
    int mcnt;
    int sent;
    int seen;
    mcnt = 0;
    sent = 0;
    seen = 0;
    for (int cyc = 0; cyc < 80 && seen < 10; cyc++) begin
      bit do_enq, do_deq;
      if (sent < 10) set_in_b(1'b1, 32'h600 + 32'(4 * sent));
      else set_in_b(1'b0, 32'h0);
      qb.OUT_READY = 1'($urandom_range(0, 1));
      #1;
      checks++; if (qb.IN_READY !== 1'(mcnt < 3)) begin errors++; $display("FAIL np2_in_ready cyc%0d got %b exp %b", cyc, qb.IN_READY, mcnt < 3); end
      checks++; if (qb.COUNT !== 2'(mcnt) || qb.COUNT > 2'd3) begin errors++; $display("FAIL np2_count cyc%0d got %0d exp %0d", cyc, qb.COUNT, mcnt); end
      checks++; if (qb.OUT_VALID !== 1'(mcnt != 0)) begin errors++; $display("FAIL np2_out_valid cyc%0d got %b exp %b", cyc, qb.OUT_VALID, mcnt != 0); end
      if (mcnt > 0) begin
        checks++; if (qb.CHECK_PC !== exp_q[0]) begin errors++; $display("FAIL np2_order cyc%0d got %h exp %h", cyc, qb.CHECK_PC, exp_q[0]); end
      end
      do_deq = (mcnt > 0) && (qb.OUT_READY == 1'b1);
      do_enq = (sent < 10) && (mcnt < 3);
      tick();
      if (do_deq) begin void'(exp_q.pop_front()); seen++; mcnt--; end
      if (do_enq) begin exp_q.push_back(32'h600 + 32'(4 * sent)); sent++; mcnt++; end
    end
    set_in_b(1'b0, 32'h0);
    qb.OUT_READY = 1'b0;
    checks++; if (seen != 10) begin errors++; $display("FAIL np2_delivered got %0d exp 10", seen); end
    $display("test_non_pow2 done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush_a = 1'b0; stall_a = 1'b0; mem_wait_a = 1'b0;
    flush_b = 1'b0; stall_b = 1'b0; mem_wait_b = 1'b0;
    set_in_a(1'b0, 32'h0, 32'h0);
    set_in_b(1'b0, 32'h0);
    qa.OUT_READY = 1'b0;
    qb.OUT_READY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_wrap();
    test_hold(1'b0);
    test_hold(1'b1);
    test_invalid();
    test_flush();
    test_non_pow2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
